// File: rtl/mastermind_game_ctrl.sv
// Mastermind round controller.
// Latches a secret code on Start, scores each guess submitted with Enter,
// counts attempts and reports the win/lose outcome.
// Ports:
//   Clock, Reset          - system clock, synchronous active-high reset
//   StartPulse            - one-cycle pulse, begins a new game (any state)
//   EnterPulse            - one-cycle pulse, submits Guess while in GUESS
//   Guess[7:0]            - four 2-bit pegs, peg i = Guess[2i+1:2i]
//   SecretSel, SecretIn   - on Start: 1 = take SecretIn, 0 = take LFSR[7:0]
//   Exact, Partial        - score of the most recent guess
//   TriesUsed             - guesses scored in this game
//   ScoreValid            - one-cycle pulse when the score outputs update
//   Playing, Win, Lose    - registered decode of the round state
module mastermind_game_ctrl #(
    parameter int unsigned MAX_TRIES = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       StartPulse,
    input  logic       EnterPulse,
    input  logic [7:0] Guess,
    input  logic       SecretSel,
    input  logic [7:0] SecretIn,
    output logic [2:0] Exact,
    output logic [2:0] Partial,
    output logic [3:0] TriesUsed,
    output logic       ScoreValid,
    output logic       Playing,
    output logic       Win,
    output logic       Lose
);

    localparam int unsigned PEGS = 4;
    localparam int unsigned COLOURS = 4;
    localparam logic [3:0] TRIES_LIMIT = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        GUESS,
        CHECK,
        WIN,
        LOSE
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [7:0]  secret_q;
    logic [7:0]  guess_q;

    logic [2:0]  exact_c;
    logic [2:0]  sum_c;
    logic [2:0]  cnt_s;
    logic [2:0]  cnt_g;
    logic [3:0]  tries_inc;
    logic        lfsr_fb;

    // Fibonacci feedback for taps 16,14,13,11 (shift-right form)
    assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign tries_inc = TriesUsed + 4'd1;

    // Score of the latched guess against the latched secret
    always_comb begin
        exact_c = '0;
        sum_c   = '0;
        cnt_s   = '0;
        cnt_g   = '0;
        for (int i = 0; i < PEGS; i++) begin
            if (guess_q[2*i +: 2] == secret_q[2*i +: 2]) begin
                exact_c = exact_c + 3'd1;
            end
        end
        // Colour-only overlap: sum of min(count in secret, count in guess)
        for (int c = 0; c < COLOURS; c++) begin
            cnt_s = '0;
            cnt_g = '0;
            for (int i = 0; i < PEGS; i++) begin
                if (secret_q[2*i +: 2] == 2'(c)) cnt_s = cnt_s + 3'd1;
                if (guess_q[2*i +: 2] == 2'(c))  cnt_g = cnt_g + 3'd1;
            end
            sum_c = sum_c + ((cnt_s < cnt_g) ? cnt_s : cnt_g);
        end
    end

    // Round state machine with registered score and status outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            secret_q   <= '0;
            guess_q    <= '0;
            Exact      <= '0;
            Partial    <= '0;
            TriesUsed  <= '0;
            ScoreValid <= 1'b0;
            Playing    <= 1'b0;
            Win        <= 1'b0;
            Lose       <= 1'b0;
        end else begin
            lfsr       <= {lfsr_fb, lfsr[15:1]};
            ScoreValid <= 1'b0;
            if (StartPulse) begin
                // Start wins over Enter and cancels a pending CHECK
                state     <= GUESS;
                secret_q  <= SecretSel ? SecretIn : lfsr[7:0];
                Exact     <= '0;
                Partial   <= '0;
                TriesUsed <= '0;
                Playing   <= 1'b1;
                Win       <= 1'b0;
                Lose      <= 1'b0;
            end else begin
                case (state)
                    GUESS: begin
                        if (EnterPulse) begin
                            guess_q <= Guess;
                            state   <= CHECK;
                        end
                    end
                    CHECK: begin
                        Exact      <= exact_c;
                        Partial    <= sum_c - exact_c;
                        TriesUsed  <= tries_inc;
                        ScoreValid <= 1'b1;
                        if (exact_c == 3'd4) begin
                            state   <= WIN;
                            Playing <= 1'b0;
                            Win     <= 1'b1;
                        end else if (tries_inc == TRIES_LIMIT) begin
                            state   <= LOSE;
                            Playing <= 1'b0;
                            Lose    <= 1'b1;
                        end else begin
                            state <= GUESS;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Scoreboard bench for mastermind_game_ctrl.
module tb_mastermind_game_ctrl;

    localparam int unsigned MAX_TRIES = 8;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       StartPulse = 1'b0;
    logic       EnterPulse = 1'b0;
    logic [7:0] Guess = '0;
    logic       SecretSel = 1'b0;
    logic [7:0] SecretIn = '0;
    logic [2:0] Exact;
    logic [2:0] Partial;
    logic [3:0] TriesUsed;
    logic       ScoreValid;
    logic       Playing;
    logic       Win;
    logic       Lose;

    mastermind_game_ctrl #(.MAX_TRIES(MAX_TRIES), .LFSR_SEED(16'hACE1)) dut (
        .Clock(Clock), .Reset(Reset), .StartPulse(StartPulse), .EnterPulse(EnterPulse),
        .Guess(Guess), .SecretSel(SecretSel), .SecretIn(SecretIn),
        .Exact(Exact), .Partial(Partial), .TriesUsed(TriesUsed),
        .ScoreValid(ScoreValid), .Playing(Playing), .Win(Win), .Lose(Lose)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int unsigned exact;
        int unsigned partial;
        int unsigned tries;
        int unsigned win;
        int unsigned lose;
        int unsigned playing;
    } score_t;

    score_t      sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] m_lfsr;
    logic [7:0]  exp_secret = '0;
    int unsigned exp_tries = 0;
    bit          exp_playing = 0;

    // Reference secret generator: 16-bit Fibonacci, taps 16,14,13,11
    always @(posedge Clock) begin
        if (Reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Classic marking algorithm: exacts first, then pair leftover pegs
    function automatic score_t ref_score(input logic [7:0] s, input logic [7:0] g);
        score_t r;
        bit used_s[4];
        bit used_g[4];
        r = '{default: 0};
        for (int i = 0; i < 4; i++) begin
            used_s[i] = 0;
            used_g[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (s[2*i +: 2] == g[2*i +: 2]) begin
                r.exact++;
                used_s[i] = 1;
                used_g[i] = 1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!used_g[i]) begin
                for (int j = 0; j < 4; j++) begin
                    if (!used_g[i] && !used_s[j] && s[2*j +: 2] == g[2*i +: 2]) begin
                        used_s[j] = 1;
                        used_g[i] = 1;
                        r.partial++;
                    end
                end
            end
        end
        return r;
    endfunction

    // Advance one cycle, then pop and compare whenever the DUT presents a score
    task automatic tick();
        score_t e;
        @(posedge Clock);
        #1;
        if (ScoreValid) begin
            if (sb.size() == 0) begin
                check("spurious_score", 1, 0);
            end else begin
                e = sb.pop_front();
                check("exact",   Exact,     e.exact);
                check("partial", Partial,   e.partial);
                check("tries",   TriesUsed, e.tries);
                check("win",     Win,       e.win);
                check("lose",    Lose,      e.lose);
                check("playing", Playing,   e.playing);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_exact"},   Exact,      0);
        check({tag, "_partial"}, Partial,    0);
        check({tag, "_tries"},   TriesUsed,  0);
        check({tag, "_sv"},      ScoreValid, 0);
        check({tag, "_playing"}, Playing,    0);
        check({tag, "_win"},     Win,        0);
        check({tag, "_lose"},    Lose,       0);
    endtask

    task automatic start_game(input bit sel, input logic [7:0] sin);
        StartPulse = 1'b1;
        SecretSel  = sel;
        SecretIn   = sin;
        exp_secret = sel ? sin : m_lfsr[7:0];
        exp_tries  = 0;
        exp_playing = 1;
        tick();
        StartPulse = 1'b0;
        check("start_tries",   TriesUsed, 0);
        check("start_exact",   Exact,     0);
        check("start_playing", Playing,   1);
        check("start_win",     Win,       0);
        check("start_lose",    Lose,      0);
    endtask

    // Submit a guess; a score is expected exactly two cycles later if playing
    task automatic do_enter(input logic [7:0] g);
        score_t e;
        EnterPulse = 1'b1;
        Guess = g;
        if (exp_playing) begin
            e = ref_score(exp_secret, g);
            exp_tries++;
            e.tries   = exp_tries;
            e.win     = (e.exact == 4) ? 1 : 0;
            e.lose    = (!e.win && exp_tries == MAX_TRIES) ? 1 : 0;
            e.playing = (e.win || e.lose) ? 0 : 1;
            exp_playing = e.playing[0];
            sb.push_back(e);
        end
        tick();
        EnterPulse = 1'b0;
        tick();
        check("score_latency", sb.size(), 0);
        tick();
    endtask

    initial begin
        tick();
        tick();
        check_idle("reset");
        Reset = 1'b0;

        // Enter while IDLE is ignored
        do_enter(8'b11_10_01_00);
        check("idle_enter_playing", Playing, 0);

        // Correct first guess wins
        start_game(1'b1, 8'b11_10_01_00);
        do_enter(8'b11_10_01_00);
        check("win1_win", Win, 1);

        // All colours misplaced, then one exact
        start_game(1'b1, 8'b11_10_01_00);
        do_enter(8'b00_01_10_11);
        do_enter(8'b11_11_11_11);

        // Repeated colours
        start_game(1'b1, 8'b00_00_01_01);
        do_enter(8'b01_01_00_10);

        // Enter held into CHECK scores only once
        EnterPulse = 1'b1;
        Guess = 8'b00_00_00_00;
        begin
            score_t e;
            e = ref_score(exp_secret, Guess);
            exp_tries++;
            e.tries = exp_tries; e.win = 0; e.lose = 0; e.playing = 1;
            sb.push_back(e);
        end
        tick();
        tick();
        EnterPulse = 1'b0;
        tick();
        tick();
        check("check_enter_sb", sb.size(), 0);
        check("check_enter_tries", TriesUsed, 2);

        // Eight misses lose; further Enter does nothing
        start_game(1'b1, 8'b11_10_01_00);
        for (int i = 0; i < 8; i++) do_enter(8'b00_00_00_00);
        check("lose_lose", Lose, 1);
        do_enter(8'b11_10_01_00);
        check("lose_hold_tries", TriesUsed, 8);
        check("lose_hold_lose",  Lose,      1);
        check("lose_hold_exact", Exact,     1);

        // Correct on the final try wins
        start_game(1'b1, 8'b11_10_01_00);
        for (int i = 0; i < 7; i++) do_enter(8'b00_00_00_00);
        do_enter(8'b11_10_01_00);
        check("last_try_win",  Win,  1);
        check("last_try_lose", Lose, 0);

        // Start and Enter together: Start wins, no scoring
        start_game(1'b1, 8'b11_10_01_00);
        do_enter(8'b00_00_00_00);
        EnterPulse = 1'b1;
        start_game(1'b1, 8'b11_10_01_00);
        EnterPulse = 1'b0;
        tick();
        tick();
        check("start_enter_tries", TriesUsed, 0);
        check("start_enter_play",  Playing,   1);

        // Start arriving in CHECK cancels that scoring
        do_enter(8'b01_01_01_01);
        EnterPulse = 1'b1;
        Guess = 8'b00_00_00_00;
        tick();
        EnterPulse = 1'b0;
        start_game(1'b1, 8'b00_00_00_00);
        tick();
        tick();
        check("cancel_tries", TriesUsed, 0);
        check("cancel_sv",    ScoreValid, 0);

        // Secret taken from the LFSR
        repeat (5) tick();
        start_game(1'b0, 8'h00);
        do_enter(8'b00_00_00_00);
        if (exp_playing) do_enter(exp_secret);
        check("lfsr_win", Win, 1);

        // Reset mid-game after three tries
        start_game(1'b1, 8'b11_10_01_00);
        for (int i = 0; i < 3; i++) do_enter(8'b11_11_00_00);
        check("pre_reset_tries", TriesUsed, 3);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_playing = 0;
        check_idle("midreset");

        // Reset overrides Start
        Reset = 1'b1;
        StartPulse = 1'b1;
        tick();
        Reset = 1'b0;
        StartPulse = 1'b0;
        check_idle("reset_start");
        tick();
        check("reset_start_after", Playing, 0);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mastermind_game_ctrl.md
Name: mastermind_game_ctrl

Overview:
Top-level round controller for the Mastermind game on the DE1-SoC. Consumes one-cycle press pulses from the button-press detectors (Start, Enter) and a switch-encoded guess. Latches a secret code, scores each guess (exact and colour-only matches), counts attempts, and drives the win/lose outcome. Sits between the per-key press detectors and the HEX/LEDR display logic.

Parameters:
MAX_TRIES, 8, number of guesses allowed per game (1..15)
LFSR_SEED, 16'hACE1, nonzero reset value of the internal secret-generator LFSR

Ports:
Clock  input  1  system clock
Reset  input  1  synchronous, active-high reset
StartPulse  input  1  one-cycle pulse: begin a new game
EnterPulse  input  1  one-cycle pulse: submit current guess
Guess  input  8  four 2-bit pegs; peg i = Guess[2i+1:2i]
SecretSel  input  1  sampled on Start: 1 = take SecretIn, 0 = take LFSR[7:0]
SecretIn  input  8  externally supplied secret (test/debug)
Exact  output  3  pegs correct colour and position (0..4)
Partial  output  3  pegs correct colour, wrong position (0..4)
TriesUsed  output  4  guesses scored this game
ScoreValid  output  1  one-cycle pulse when Exact/Partial/TriesUsed update
Playing  output  1  high in GUESS and CHECK
Win  output  1  high in WIN
Lose  output  1  high in LOSE

Behaviour:
- Reset: state IDLE; Exact=0, Partial=0, TriesUsed=0, ScoreValid=0, Playing=0, Win=0, Lose=0; secret register=0; LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every non-reset cycle in every state.
- States: IDLE, GUESS, CHECK, WIN, LOSE. Win/Lose/Playing are Moore outputs of the state register.
- StartPulse in any state (including GUESS and CHECK): next state GUESS. Secret <= (SecretSel ? SecretIn : LFSR[7:0]). TriesUsed, Exact, Partial <= 0. ScoreValid <= 0. A Start arriving in CHECK cancels that scoring.
- StartPulse and EnterPulse high in the same cycle: Start has priority, and Enter is discarded.
- GUESS with EnterPulse (no Start): latch Guess into the guess register, then go to CHECK. Enter is ignored in IDLE, CHECK, WIN and LOSE.
- CHECK lasts exactly one cycle. It registers the following:
  - Exact = count of i with guess_i == secret_i.
  - Partial = sum over colours c of min(cnt_secret(c), cnt_guess(c)), minus Exact.
  - TriesUsed <= TriesUsed + 1.
  - ScoreValid <= 1.
- CHECK next state:
  - WIN if Exact == 4 (this takes priority, including on the final try).
  - Otherwise LOSE if TriesUsed+1 == MAX_TRIES.
  - Otherwise GUESS.
- Latency: Enter high in cycle k, state CHECK in cycle k+1, and in cycle k+2 the new Exact/Partial/TriesUsed are visible, ScoreValid=1, and state is GUESS/WIN/LOSE.
- ScoreValid is high for exactly one cycle per scored guess and is otherwise 0.
- Exact/Partial/TriesUsed hold their values until the next CHECK or Start.
- WIN and LOSE are terminal until StartPulse or Reset.
- Reset mid-game (any state) returns to the full reset state on the next edge and overrides Start and Enter.
- Width rules: the colour counts are 3 bits and the intermediate sum is 3 bits. Partial never underflows, because the sum is always >= Exact.

Test Plan:
- Reset, Start with SecretSel=1, SecretIn=8'b11_10_01_00, Enter with Guess=8'b11_10_01_00 -> two cycles after Enter: Exact=4, Partial=0, TriesUsed=1, ScoreValid pulse, Win=1, Playing=0.
- Same secret, Guess=8'b00_01_10_11 -> Exact=0, Partial=4, TriesUsed=1, back in GUESS (Playing=1). Then Guess=8'b11_11_11_11 -> Exact=1, Partial=0, TriesUsed=2.
- Secret 8'b00_00_01_01, Guess=8'b01_01_00_10 -> Exact=0, Partial=3.
- Eight wrong guesses (Guess=8'b00_00_00_00 vs secret 8'b11_10_01_00) -> after the 8th, Exact=1, TriesUsed=8, Lose=1. A further Enter gives no ScoreValid and no change. A final guess that is correct on try 8 -> Win=1, not Lose.
- Enter while IDLE and while in CHECK is ignored (no extra ScoreValid). Start+Enter in the same GUESS cycle -> TriesUsed=0, state GUESS, no scoring. Start with SecretSel=0 latches LFSR[7:0] (compare against a model seeded with 16'hACE1).
- Reset asserted in GUESS after 3 tries -> next cycle all outputs 0, state IDLE. Reset held together with Start -> stays IDLE.
